// File: rtl/weighted_rect_accum.sv
// Weighted rectangle accumulator: walks a weight ROM, multiplies each incoming rectangle sum by
// its weight and emits one feature sum per feature. CASCADE_ACC_SAT_EN selects saturating accumulation.
module weighted_rect_accum #(
    parameter int W_DATA    = 3,
    parameter int W_ADDR    = 8,
    parameter int N_ENTRIES = 136,
    parameter int W_SUM     = 18,
    parameter int W_ACC     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [W_ADDR-1:0] rom_addr,
    input  logic [W_DATA-1:0] rom_data,
    input  logic              rect_valid,
    output logic              rect_ready,
    input  logic [W_SUM-1:0]  rect_sum,
    input  logic              rect_last,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic [W_ACC-1:0]  feat_sum,
    output logic [1:0]        dbg_state
);

    // Both handshakes transfer on a rising edge where valid and ready are both high; valid never
    // depends on ready, and feat_valid/feat_sum hold steady until feat_ready is seen.
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} state_t;

    localparam int P_W = W_SUM + W_DATA + 1;
    localparam int X_W = ((P_W > W_ACC) ? P_W : W_ACC) + 1;
    localparam logic [W_ADDR-1:0] LAST_IDX = W_ADDR'(N_ENTRIES - 1);

    state_t              state_q, state_d;
    logic [W_ADDR-1:0]   cnt_q, cnt_d;
    logic [W_ACC-1:0]    acc_q, acc_d;
    logic [W_DATA-1:0]   weight_q, weight_d;
    logic                wait_first_q, wait_first_d;
    logic                exhausted_q, exhausted_d;
    logic [W_ADDR-1:0]   rom_addr_q, rom_addr_d;
    logic                done_q, done_d;
    logic [W_ACC-1:0]    feat_sum_q, feat_sum_d;

    logic [W_DATA-1:0]   w_eff;
    logic signed [P_W-1:0] prod;
    logic signed [X_W-1:0] sum_x;
    logic [W_ACC-1:0]    acc_sum;

`ifdef CASCADE_ACC_SAT_EN
    localparam logic signed [X_W-1:0] ACC_MAX = {{(X_W-W_ACC+1){1'b0}}, {(W_ACC-1){1'b1}}};
    localparam logic signed [X_W-1:0] ACC_MIN = {{(X_W-W_ACC+1){1'b1}}, {(W_ACC-1){1'b0}}};
`endif

    // ROM data arrives during the first WAIT cycle, so use it directly until it is registered.
    always_comb begin
        w_eff = wait_first_q ? rom_data : weight_q;
        prod  = P_W'($signed(rect_sum)) * P_W'($signed({1'b0, w_eff}));
        sum_x = X_W'($signed(acc_q)) + X_W'(prod);
`ifdef CASCADE_ACC_SAT_EN
        if (sum_x > ACC_MAX) begin
            acc_sum = W_ACC'(ACC_MAX);
        end else if (sum_x < ACC_MIN) begin
            acc_sum = W_ACC'(ACC_MIN);
        end else begin
            acc_sum = W_ACC'(sum_x);
        end
`else
        acc_sum = W_ACC'(sum_x);
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        weight_d     = weight_q;
        wait_first_d = 1'b0;
        exhausted_d  = exhausted_q;
        rom_addr_d   = rom_addr_q;
        done_d       = 1'b0;
        feat_sum_d   = feat_sum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d       = '0;
                    acc_d       = '0;
                    exhausted_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                wait_first_d = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (wait_first_q) begin
                    weight_d = rom_data;
                end
                if (rect_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        exhausted_d = 1'b1;
                    end
                    if (rect_last || (cnt_q == LAST_IDX)) begin
                        feat_sum_d = acc_sum;
                        state_d    = OUT;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            OUT: begin
                if (feat_ready) begin
                    acc_d = '0;
                    if (exhausted_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The address register only moves when a fetch begins, so it never shows a past-end index.
        if (state_d == FETCH) begin
            rom_addr_d = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            weight_q     <= '0;
            wait_first_q <= 1'b0;
            exhausted_q  <= 1'b0;
            rom_addr_q   <= '0;
            done_q       <= 1'b0;
            feat_sum_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            weight_q     <= weight_d;
            wait_first_q <= wait_first_d;
            exhausted_q  <= exhausted_d;
            rom_addr_q   <= rom_addr_d;
            done_q       <= done_d;
            feat_sum_q   <= feat_sum_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign rom_en     = (state_q == FETCH);
    assign rom_addr   = rom_addr_q;
    assign rect_ready = (state_q == WAIT);
    assign feat_valid = (state_q == OUT);
    assign feat_sum   = feat_sum_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/weighted_rect_accum.md
WEIGHTED_RECT_ACCUM -- requirements
Module: weighted_rect_accum

Interface
REQ-001 Parameters: W_DATA, default 3, width of one rectangle weight word.
REQ-002 Parameters: W_ADDR, default 8, weight-ROM address width.
REQ-003 Parameters: N_ENTRIES, default 136, number of valid weight-ROM entries.
REQ-004 Parameters: W_SUM, default 18, signed rectangle-sum width.
REQ-005 Parameters: W_ACC, default 24, signed feature-sum width.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a pass over the weight table.
- busy  out  1  high from the cycle after an accepted start until the end of the pass.
- done  out  1  single-cycle pulse at the end of a pass.
- rom_en  out  1  weight-ROM read enable.
- rom_addr  out  W_ADDR  weight-ROM read address.
- rom_data  in  W_DATA  weight-ROM read data, valid one cycle after rom_en.
- rect_valid  in  1  upstream rectangle sum is valid.
- rect_ready  out  1  block accepts a rectangle sum.
- rect_sum  in  W_SUM  signed rectangle sum.
- rect_last  in  1  this rectangle is the last one of its feature.
- feat_valid  out  1  feature sum is valid.
- feat_ready  in  1  downstream accepts the feature sum.
- feat_sum  out  W_ACC  signed weighted feature sum.

Function
REQ-008 The FSM SHALL have four states: IDLE, FETCH, WAIT, OUT.
REQ-009 IDLE: on start, the address counter is cleared to 0, the accumulator is cleared, and the FSM moves to FETCH.
- start is ignored in every state other than IDLE.
REQ-010 FETCH: the block drives rom_en=1 and rom_addr=counter for exactly one cycle, then moves to WAIT.
- rom_en SHALL be 0 in every other state.
REQ-011 WAIT: the block captures rom_data into a weight register on entry and holds rect_ready=1 for the whole state.
REQ-012 Weight arithmetic: the weight is zero-extended and treated as signed. The product rect_sum*weight is signed, W_SUM+W_DATA+1 bits, and is sign-extended to W_ACC before it is added.
REQ-013 On a handshake in WAIT (rect_valid & rect_ready):
- acc <= acc + product;
- the counter increments.
- If rect_last=1, or the counter equals N_ENTRIES-1, the FSM moves to OUT.
- Otherwise the FSM moves to FETCH.
REQ-014 OUT:
- feat_valid=1 and feat_sum=acc are registered, visible the cycle after the handshake, and held stable until feat_ready=1.
- rect_ready=0 in OUT.
REQ-015 On feat_valid & feat_ready:
- the accumulator clears.
- If the table is exhausted (the last accepted entry was N_ENTRIES-1), the FSM moves to IDLE and done pulses for one cycle in that same transition.
- Otherwise the FSM moves to FETCH.
REQ-016 End of table: when the table is exhausted, the feature is closed even if rect_last=0. Entries at or above N_ENTRIES SHALL never be addressed.
REQ-017 Throughput: a minimum of 2 cycles per rectangle (FETCH+WAIT). Latency from the last rectangle handshake to feat_valid is 1 cycle.
REQ-018 busy=1 in FETCH, WAIT and OUT, and busy=0 in IDLE.

Reset
REQ-019 Asserting rst (low) at any time, including mid-pass, SHALL immediately force:
- the FSM to IDLE;
- counter, accumulator, weight register, busy, done, rom_en, rect_ready, feat_valid and feat_sum to 0;
- rom_addr to 0.
REQ-020 After rst deasserts, no output changes until the next start.

Configuration
REQ-021 Macro CASCADE_ACC_SAT_EN:
- Defined: each accumulate saturates to the W_ACC signed maximum or minimum.
- Undefined: each accumulate wraps modulo 2^W_ACC (two's complement truncation).

Verification
REQ-022 Weights at entries 0-1 are 3. start; rect_sum 100, then -50 with rect_last -> feat_sum=150, one cycle after the second handshake.
REQ-023 rect_valid is held low for 5 cycles in WAIT -> rect_ready stays 1, the counter and accumulator are unchanged, and there is no extra rom_en pulse.
REQ-024 feat_ready is held low for 4 cycles -> feat_valid and feat_sum are stable, and no rom_en is issued until feat_ready=1.
REQ-025 Full pass of 136 rectangles, rect_last never asserted -> exactly one feature at entry 135, then done pulses once, busy falls, and rom_addr never exceeds 135.
REQ-026 W_ACC=8, weight 3, rect_sum 60 twice -> 0x7F with CASCADE_ACC_SAT_EN defined; 360 mod 256 = 104 (0x68) when undefined.
REQ-027 rst pulled low while in WAIT mid-feature -> all outputs read 0 within the same cycle. A later start restarts at rom_addr=0 with the accumulator at 0.
